// File: rtl/vga_sync_decoder_if.sv
`timescale 1ns/1ps
// Sampled VGA sync/colour inputs and the recovered pixel stream, grouped as one bus.
// master drives the raw video and observes the decode; slave is the decoder side.
interface vga_sync_decoder_if;
    logic        pix_en;
    logic        h_sync;
    logic        v_sync;
    logic [3:0]  in_r;
    logic [3:0]  in_g;
    logic [3:0]  in_b;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active;
    logic [11:0] rgb_out;
    logic        frame_start;
    logic        locked;
    logic        timing_err;

    modport master (
        output pix_en, h_sync, v_sync, in_r, in_g, in_b,
        input  x, y, active, rgb_out, frame_start, locked, timing_err
    );

    modport slave (
        input  pix_en, h_sync, v_sync, in_r, in_g, in_b,
        output x, y, active, rgb_out, frame_start, locked, timing_err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
`timescale 1ns/1ps
// Recovers active-area x/y/colour from raw VGA syncs and tracks lock to the line/frame timing.
// Latency: pixel sampled on strobe N is presented on the clk edge of strobe N+1.
// Backpressure: none; the decoder follows pix_en and holds its outputs between strobes.
module vga_sync_decoder #(
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic              clk,
    input  logic              reset,
    vga_sync_decoder_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    typedef struct packed {
        logic        active;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    localparam logic [10:0] HCNT_MAX = 11'd2047;
    localparam logic [9:0]  VCNT_MAX = 10'd1023;
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_LO     = 11'(H_START);
    localparam logic [10:0] H_HI     = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_LO     = 10'(V_START);
    localparam logic [9:0]  V_HI     = 10'(V_START + V_ACTIVE);

    state_t      state;
    logic [10:0] hcnt;
    logic [10:0] hcnt_n;
    logic [9:0]  vcnt;
    logic [9:0]  vcnt_n;
    logic        hs_prev;
    logic        vs_prev;
    logic        vpend;
    logic        vpend_n;
    logic        err_flag;
    logic        hs_edge;
    logic        vs_edge;
    logic        frame_now;
    logic        err_now;
    logic        in_win;
    logic        frame_start_q;
    logic        timing_err_q;
    pix_t        stage;
    pix_t        stage_n;
    pix_t        out_pix;

    always_comb begin
        hs_edge   = !bus.h_sync && hs_prev;
        vs_edge   = !bus.v_sync && vs_prev;
        vpend_n   = vpend || vs_edge;
        frame_now = hs_edge && vpend_n;

        hcnt_n = hcnt;
        if (hs_edge)
            hcnt_n = '0;
        else if (hcnt != HCNT_MAX)
            hcnt_n = hcnt + 11'd1;

        vcnt_n = vcnt;
        if (frame_now)
            vcnt_n = '0;
        else if (hs_edge && vcnt != VCNT_MAX)
            vcnt_n = vcnt + 10'd1;

        // Length checks use the counts reached just before the re-alignment.
        err_now = (state != SEARCH) &&
                  ((hs_edge && hcnt != H_LAST) || (frame_now && vcnt != V_LAST));

        in_win  = (hcnt_n >= H_LO) && (hcnt_n < H_HI) && (vcnt_n >= V_LO) && (vcnt_n < V_HI);
        stage_n = '0;
        if (in_win) begin
            stage_n.active = 1'b1;
            stage_n.x      = 10'(hcnt_n - H_LO);
            stage_n.y      = 10'(vcnt_n - V_LO);
            stage_n.rgb    = {bus.in_r, bus.in_g, bus.in_b};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= SEARCH;
            hcnt          <= '0;
            vcnt          <= '0;
            hs_prev       <= 1'b1;
            vs_prev       <= 1'b1;
            vpend         <= 1'b0;
            err_flag      <= 1'b0;
            stage         <= '0;
            out_pix       <= '0;
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
            if (bus.pix_en) begin
                hs_prev       <= bus.h_sync;
                vs_prev       <= bus.v_sync;
                hcnt          <= hcnt_n;
                vcnt          <= vcnt_n;
                vpend         <= vpend_n && !hs_edge;
                frame_start_q <= frame_now;
                timing_err_q  <= err_now;
                stage         <= stage_n;
                // state here already reflects the strobe that captured stage
                out_pix       <= (stage.active && state == LOCKED) ? stage : '0;
                if (err_now)
                    err_flag <= 1'b1;

                case (state)
                    SEARCH: if (frame_now) begin
                        state    <= ACQUIRE;
                        err_flag <= 1'b0;
                    end
                    ACQUIRE: if (frame_now) begin
                        // A frame that saw an error is only consumed, never qualified.
                        if (err_flag || err_now)
                            err_flag <= err_now;
                        else
                            state <= LOCKED;
                    end
                    LOCKED: if (err_now)
                        state <= ACQUIRE;
                    default: state <= SEARCH;
                endcase

                if (hcnt_n == HCNT_MAX)
                    state <= SEARCH;
            end
        end
    end

    assign bus.x           = out_pix.x;
    assign bus.y           = out_pix.y;
    assign bus.active      = out_pix.active;
    assign bus.rgb_out     = out_pix.rgb;
    assign bus.frame_start = frame_start_q;
    assign bus.timing_err  = timing_err_q;
    assign bus.locked      = (state == LOCKED);
endmodule

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns/1ps
// Bench for vga_sync_decoder on a scaled-down raster: frame scenarios from a table,
// every strobe and idle clk compared against a frame-counting reference model.
module tb_vga_sync_decoder;
    localparam int HS = 6;
    localparam int HA = 8;
    localparam int HT = 20;
    localparam int VS = 3;
    localparam int VA = 4;
    localparam int VT = 10;

    logic clk = 1'b0;
    logic reset;

    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .H_START(HS), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_START(VS), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lines;
        int short_line;
        bit early_next;
        bit spot;
        int exp_fs;
        int exp_err;
        bit exp_locked;
    } frame_vec_t;

    int checks   = 0;
    int failures = 0;
    int fs_cnt;
    int err_cnt;
    bit gap_fixed;

    // Reference model: position in line, line in frame, and count of clean frame starts.
    int          m_pos;
    int          m_line;
    int          m_good;
    bit          m_armed;
    bit          m_phs;
    bit          m_pvs;
    bit          m_vpend;
    logic [32:0] m_pipe;
    logic [35:0] m_exp;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] dut_vec();
        return {bus.active, bus.x, bus.y, bus.rgb_out, bus.frame_start, bus.timing_err, bus.locked};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_line = 0; m_good = 0; m_armed = 0;
        m_phs = 1; m_pvs = 1; m_vpend = 0; m_pipe = '0; m_exp = '0;
    endtask

    task automatic model_step(input bit hs, input bit vs, input logic [11:0] rgb);
        bit hedge, vedge, pend, fs, err, win;
        hedge = m_phs && !hs;
        vedge = m_pvs && !vs;
        m_phs = hs;
        m_pvs = vs;
        pend  = m_vpend || vedge;
        fs    = 0;
        err   = 0;
        if (hedge) begin
            if (m_armed && m_pos != HT - 1) err = 1;
            if (pend) begin
                fs = 1;
                if (m_armed && m_line != VT - 1) err = 1;
                m_line = 0;
            end else if (m_line < 1023) begin
                m_line++;
            end
            m_pos   = 0;
            m_vpend = 0;
        end else begin
            if (m_pos < 2047) m_pos++;
            m_vpend = pend;
        end
        if (err) m_good = 0;
        else if (fs) begin
            m_armed = 1;
            if (m_good < 2) m_good++;
        end
        if (m_pos == 2047) begin
            m_armed = 0;
            m_good  = 0;
        end
        win    = (m_good >= 2) && m_pos >= HS && m_pos < HS + HA && m_line >= VS && m_line < VS + VA;
        m_exp  = {m_pipe, fs, err, (m_good >= 2)};
        m_pipe = win ? {1'b1, 10'(m_pos - HS), 10'(m_line - VS), rgb} : 33'd0;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic strobe(input bit hs, input bit vs, input logic [11:0] rgb);
        int gap;
        bus.pix_en = 1'b1;
        bus.h_sync = hs;
        bus.v_sync = vs;
        {bus.in_r, bus.in_g, bus.in_b} = rgb;
        model_step(hs, vs, rgb);
        @(posedge clk); #1;
        check("strobe", dut_vec(), m_exp);
        fs_cnt  += int'(bus.frame_start);
        err_cnt += int'(bus.timing_err);
        gap = gap_fixed ? 3 : int'($urandom_range(1, 3));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.pix_en = 1'b0;
            if (g == 0) begin
                bus.h_sync = 1'($urandom);
                bus.v_sync = 1'($urandom);
                {bus.in_r, bus.in_g, bus.in_b} = 12'($urandom);
            end
            @(posedge clk); #1;
            check("hold", dut_vec(), m_exp & ~36'h6);
        end
        @(negedge clk);
    endtask

    task automatic spot_checks(input int l, input int i);
        if (l == VS && i == HS + 1)
            check("first_px", {3'd0, bus.active, bus.x, bus.y, bus.rgb_out}, {3'd0, 1'b1, 10'd0, 10'd0, 12'hF80});
        if (l == VS && i == HS + HA + 1)
            check("right_edge_off", {3'd0, bus.active, bus.x, bus.y, bus.rgb_out}, 36'd0);
        if (l == VS - 1 && i == HS + 1)
            check("top_edge_off", {3'd0, bus.active, bus.x, bus.y, bus.rgb_out}, 36'd0);
        if (l == VS + VA - 1 && i == HS + HA)
            check("last_px", {15'd0, bus.active, bus.x, bus.y}, {15'd0, 1'b1, 10'(HA - 1), 10'(VA - 1)});
    endtask

    task automatic drive_frame(input int lines, input int short_line, input bit early_next, input bit spot);
        for (int l = 0; l < lines; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int i = 0; i < len; i++) begin
                bit hs, vs;
                logic [11:0] rgb;
                hs  = (i >= 2);
                vs  = (l >= 2);
                rgb = 12'($urandom);
                if (early_next && l == lines - 1 && i >= len - 3) vs = 0;
                if (spot && l == VS && i == HS) rgb = 12'hF80;
                strobe(hs, vs, rgb);
                if (spot) spot_checks(l, i);
            end
        end
    endtask

    task automatic run_frame(input string name, input frame_vec_t v);
        fs_cnt  = 0;
        err_cnt = 0;
        drive_frame(v.lines, v.short_line, v.early_next, v.spot);
        check({name, "_fs"},     36'(fs_cnt),  36'(v.exp_fs));
        check({name, "_err"},    36'(err_cnt), 36'(v.exp_err));
        check({name, "_locked"}, {35'd0, bus.locked}, {35'd0, v.exp_locked});
    endtask

    frame_vec_t tbl[11];
    frame_vec_t fv;

    initial begin
        tbl = '{
            '{10, -1, 0, 0, 1, 0, 0},   // first frame_start: acquire
            '{10, -1, 0, 0, 1, 0, 1},   // second: lock
            '{10, -1, 1, 0, 1, 0, 1},   // v_sync falls before the next line-0 h_sync
            '{10, -1, 0, 1, 1, 0, 1},   // pending v_sync aligns; active-area spot checks
            '{10,  4, 0, 0, 1, 1, 0},   // short line drops lock
            '{10, -1, 0, 0, 1, 0, 0},
            '{10, -1, 0, 0, 1, 0, 1},   // relock on second clean frame_start
            '{ 9, -1, 0, 0, 1, 0, 1},   // 9-line frame, reported at next alignment
            '{10, -1, 0, 0, 1, 1, 0},
            '{10, -1, 0, 0, 1, 0, 0},
            '{10, -1, 0, 0, 1, 0, 1}
        };

        reset      = 1'b0;
        bus.pix_en = 1'b0;
        bus.h_sync = 1'b1;
        bus.v_sync = 1'b1;
        {bus.in_r, bus.in_g, bus.in_b} = 12'h0;
        gap_fixed  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_state", dut_vec(), 36'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 11; k++) begin
            gap_fixed = (k < 2);
            run_frame($sformatf("frame%0d", k), tbl[k]);
        end

        // Sync loss: h_sync never asserts for 2048 strobes.
        for (int s = 0; s < 2048; s++) strobe(1'b1, 1'b1, 12'($urandom));
        check("sync_loss", {23'd0, bus.locked, bus.active, bus.rgb_out}, 36'd0);
        fv = '{10, -1, 0, 0, 1, 0, 0};
        run_frame("after_loss_a", fv);
        fv = '{10, -1, 0, 0, 1, 0, 1};
        run_frame("after_loss_b", fv);

        // Asynchronous reset in the middle of a line while locked.
        for (int i = 0; i < HS + 3; i++) strobe(i >= 2, 1'b0, 12'($urandom));
        for (int i = 0; i < HS + 3; i++) strobe(1'b1, 1'b1, 12'($urandom));
        check("pre_reset_locked", {35'd0, bus.locked}, 36'd1);
        #2 reset = 1'b0;
        #1 check("async_reset", dut_vec(), 36'd0);
        model_reset();
        @(posedge clk); #1 check("reset_hold", dut_vec(), 36'd0);
        @(negedge clk);
        reset = 1'b1;
        fv = '{10, -1, 0, 0, 1, 0, 0};
        run_frame("after_reset_a", fv);
        fv = '{10, -1, 0, 0, 1, 0, 1};
        run_frame("after_reset_b", fv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_START, 144: pixel strobes from the h_sync assertion edge to the first active pixel (sync 96 + back porch 48).
REQ-002 Parameter H_ACTIVE, 640: active pixels per line.
REQ-003 Parameter H_TOTAL, 800: pixel strobes per line.
REQ-004 Parameter V_START, 35: lines from the v_sync-aligned line 0 to the first active line (sync 2 + back porch 33).
REQ-005 Parameter V_ACTIVE, 480: active lines per frame.
REQ-006 Parameter V_TOTAL, 525: lines per frame.
REQ-007 clk  in  1  system clock; all state SHALL change only on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-009 pix_en  in  1  pixel strobe, one clk wide; all inputs below SHALL be sampled only when pix_en=1.
REQ-010 h_sync, v_sync  in  1 each  active-low sync inputs.
REQ-011 in_r, in_g, in_b  in  4 each  pixel colour.
REQ-012 x, y  out  10 each  recovered active-area coordinates.
REQ-013 active  out  1  high when x/y/rgb_out describe a valid active pixel.
REQ-014 rgb_out  out  12  captured colour {r,g,b}; zero when active=0.
REQ-015 frame_start  out  1  one-clk pulse at each frame re-alignment.
REQ-016 locked  out  1  high in state LOCKED.
REQ-017 timing_err  out  1  one-clk pulse on any line or frame length violation.

Function
REQ-018 On each strobe, the decoder SHALL register h_sync and v_sync into hs_prev and vs_prev; an assertion edge is sampled 0 with prev 1.
REQ-019 hcnt (11 bit) SHALL load 0 on an h_sync assertion edge; otherwise it SHALL increment per strobe and saturate at 2047.
REQ-020 vcnt (10 bit) SHALL increment on each h_sync assertion edge and saturate at 1023.
REQ-021 A v_sync assertion edge SHALL set vpend.
REQ-022 The next h_sync assertion edge with vpend set (including the same strobe) SHALL load vcnt=0, clear vpend, and pulse frame_start.
REQ-023 Line check: at an h_sync assertion edge, when the previous hcnt is not H_TOTAL-1 and the state is not SEARCH, timing_err SHALL pulse.
REQ-024 Frame check: at a vcnt=0 load, when the previous vcnt is not V_TOTAL-1 and the state is not SEARCH, timing_err SHALL pulse.
REQ-025 FSM SEARCH -> ACQUIRE: on the first frame_start.
REQ-026 FSM ACQUIRE -> LOCKED: on the next frame_start, provided no timing_err occurred since entering ACQUIRE.
REQ-027 FSM ACQUIRE stays ACQUIRE: on any timing_err, the error flag SHALL be cleared and the next frame_start re-evaluated.
REQ-028 FSM LOCKED -> ACQUIRE: on any timing_err, in the same clk.
REQ-029 FSM any state -> SEARCH: when hcnt saturates at 2047 (sync loss).
REQ-030 Latency: a pixel sampled at strobe N SHALL appear on x, y, active and rgb_out at the clk edge of strobe N+1.
REQ-031 Outputs SHALL hold between strobes.
REQ-032 active SHALL be 1 only when locked=1, H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE.
REQ-033 When active=1, the decoder SHALL drive x=hcnt-H_START, y=vcnt-V_START and rgb_out={in_r,in_g,in_b}.
REQ-034 When active=0, x, y and rgb_out SHALL be 0.
REQ-035 Strobes with pix_en=0 SHALL change no state.
REQ-036 frame_start and timing_err SHALL assert only on strobe edges.

Reset
REQ-037 reset=0 SHALL immediately force: state SEARCH; hcnt=vcnt=0; hs_prev=vs_prev=1; vpend=0; all outputs 0.
REQ-038 Reset asserted mid-frame SHALL discard lock; after release, lock SHALL require two further frame_starts.

Verification
REQ-039 Two clean 800x525 frames, pix_en every 4th clk -> frame_start twice, locked=1 after the second, timing_err never asserted.
REQ-040 Locked, line 35, strobe hcnt=144, in=0xF80 -> next strobe edge gives active=1, x=0, y=0, rgb_out=0xF80; hcnt=783, line 514 -> x=639, y=479.
REQ-041 Locked, one line shortened to 799 strobes -> timing_err one-clk pulse, locked=0 the same clk, relock at the second following clean frame_start.
REQ-042 h_sync held high for 2048 strobes -> state SEARCH, active=0, rgb_out=0.
REQ-043 v_sync and h_sync asserting on the same strobe -> vcnt=0 and frame_start on that strobe; a frame of 524 lines -> timing_err.
REQ-044 reset pulsed low mid-line while locked -> all outputs 0 asynchronously; locked=0 until two clean frame_starts.
